sseg_mux_n: RTL and testbench

Time-multiplexed seven-segment driver for a parametrised number of digits, running entirely in the i_clk domain. It uses a clock-enable prescaler and does not derive a slow clock. It adds per-digit enable with skipping of disabled digits, an anti-ghosting blank guard at each digit change, registered glitch-free outputs and a frame-start strobe. It sits between the hex/segment encoders and the board's anode/cathode pins.

---
 rtl/sseg_mux_n_pkg.sv | 34 +++
 rtl/sseg_mux_n_tick_gen.sv | 23 ++
 rtl/sseg_mux_n.sv | 83 ++++++++
 tb/tb_sseg_mux_n.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sseg_mux_n_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment driver.
// All segment patterns are active-low, bit order {dp,g,f,e,d,c,b,a}.
package sseg_pkg;

    // Pattern that turns every segment off.
    localparam logic [7:0] SEG_BLANK_N = 8'hFF;

    // Hex digit to segment pattern, decimal point off.
    localparam logic [7:0] SEG_HEX_N [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Next enabled index strictly after idx, wrapping around a 16-wide
    // enable vector. Unused digit positions must be zero-padded. Returns
    // idx itself when it is the only enabled digit and 0 when none is.
    function automatic logic [3:0] next_enabled(input logic [3:0]  idx,
                                                input logic [15:0] en);
        logic [3:0] res;
        logic [3:0] cand;
        logic       found;
        res   = '0;
        found = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            cand = idx + 4'(k);
            if (!found && en[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sseg_mux_n_tick_gen.sv
// Free-running prescaler counter. o_tick is high on the clock where the
// count is all ones, i.e. the last clock of every 2**TICK_N period.
module tick_gen #(
    parameter int TICK_N = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic [TICK_N-1:0] o_count,
    output logic              o_tick
);

    // Counter wraps naturally at 2**TICK_N.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_count <= '0;
        end else begin
            o_count <= o_count + 1'b1;
        end
    end

    assign o_tick = &o_count;

endmodule

// File: rtl/sseg_mux_n.sv
// Time-multiplexed seven-segment driver for N_DIGITS digits in the i_clk
// domain. Each digit slot lasts 2**TICK_N clocks and opens with
// BLANK_CYCLES clocks of all-off to stop ghosting on the previous digit.
// Disabled digits are skipped at slot boundaries. Outputs are registered.
// Optional macro SSEG_MUX_DIM_EN adds a 4-bit brightness input that gates
// the display with a 16-phase PWM taken from the top of the prescaler.
module sseg_mux_n
    import sseg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int TICK_N       = 15,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [N_DIGITS-1:0][7:0] i_in_n,
    input  logic [N_DIGITS-1:0]      i_digit_en,
`ifdef SSEG_MUX_DIM_EN
    input  logic [3:0]               i_bright,
`endif
    output logic [N_DIGITS-1:0]      o_ldsel,
    output logic [7:0]               o_sseg_n,
    output logic                     o_frame_start
);

    logic [TICK_N-1:0] r_div;
    logic              tick;
    logic [3:0]        r_idx;
    logic [15:0]       en_pad;
    logic [15:0][7:0]  in_pad;
    logic [3:0]        nxt_idx;
    logic [3:0]        low_idx;
    logic              show;

    tick_gen #(.TICK_N(TICK_N)) u_tick_gen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .o_count (r_div),
        .o_tick  (tick)
    );

    // Pad digit inputs to 16 so a 4-bit index is always in range; absent
    // digits read as disabled and blank.
    always_comb begin
        en_pad                   = '0;
        en_pad[N_DIGITS-1:0]     = i_digit_en;
        in_pad                   = {16{SEG_BLANK_N}};
        in_pad[N_DIGITS-1:0]     = i_in_n;
    end

    // Slot scheduling: searching from the top index wraps to the lowest
    // enabled digit, which marks the start of a scan frame.
    always_comb begin
        nxt_idx = next_enabled(r_idx, en_pad);
        low_idx = next_enabled(4'd15, en_pad);
    end

    // Display gate: current digit enabled and past the blank guard.
    always_comb begin
        show = en_pad[r_idx] && (r_div >= TICK_N'(BLANK_CYCLES));
`ifdef SSEG_MUX_DIM_EN
        show = show && (r_div[TICK_N-1 -: 4] < i_bright);
`endif
    end

    // Digit index advance and registered pin drive.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx         <= '0;
            o_ldsel       <= '0;
            o_sseg_n      <= SEG_BLANK_N;
            o_frame_start <= 1'b0;
        end else begin
            if (tick) begin
                r_idx <= nxt_idx;
            end
            o_frame_start <= tick && (|en_pad) && (nxt_idx == low_idx);
            o_ldsel       <= show ? (N_DIGITS'(1) << r_idx) : '0;
            o_sseg_n      <= show ? in_pad[r_idx] : SEG_BLANK_N;
        end
    end

endmodule

// File: tb/tb_sseg_mux_n.sv
// Randomised bench for sseg_mux_n with a cycle-level reference model built
// from slot arithmetic and a plain search over the enable array.
module tb_sseg_mux_n;
    import sseg_pkg::*;

    localparam int N     = 4;
`ifdef SSEG_MUX_DIM_EN
    localparam int TN    = 6;
`else
    localparam int TN    = 4;
`endif
    localparam int BLANK = 2;
    localparam int SLOT  = 1 << TN;

    logic              clk;
    logic              rst;
    logic [N-1:0][7:0] in_n;
    logic [N-1:0]      en;
    logic [N-1:0]      ldsel;
    logic [7:0]        sseg_n;
    logic              fs;
`ifdef SSEG_MUX_DIM_EN
    logic [3:0]        bright;
`endif

    sseg_mux_n #(.N_DIGITS(N), .TICK_N(TN), .BLANK_CYCLES(BLANK)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_in_n        (in_n),
        .i_digit_en    (en),
`ifdef SSEG_MUX_DIM_EN
        .i_bright      (bright),
`endif
        .o_ldsel       (ldsel),
        .o_sseg_n      (sseg_n),
        .o_frame_start (fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: position in slot, current digit, expected pins.
    int          m_pos;
    int          m_idx;
    logic [N-1:0] e_ldsel;
    logic [7:0]   e_sseg;
    logic         e_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int model_next(input int idx, input logic [N-1:0] e);
        for (int k = 1; k <= N; k++) begin
            if (e[(idx + k) % N]) return (idx + k) % N;
        end
        return 0;
    endfunction

    function automatic int model_lowest(input logic [N-1:0] e);
        for (int c = 0; c < N; c++) if (e[c]) return c;
        return -1;
    endfunction

    // Advance model by one rising edge using the inputs currently driven.
    task automatic model_step();
        bit on;
        int nx;
        if (rst) begin
            m_pos = 0; m_idx = 0;
            e_ldsel = '0; e_sseg = 8'hFF; e_fs = 1'b0;
        end else begin
            on = en[m_idx] && (m_pos >= BLANK);
`ifdef SSEG_MUX_DIM_EN
            on = on && ((m_pos / (SLOT / 16)) < int'(bright));
`endif
            e_ldsel = on ? N'(1 << m_idx) : '0;
            e_sseg  = on ? in_n[m_idx] : 8'hFF;
            e_fs    = 1'b0;
            if (m_pos == SLOT - 1) begin
                nx = model_next(m_idx, en);
                e_fs = (en != 0) && (nx == model_lowest(en));
                m_idx = nx;
            end
            m_pos = (m_pos + 1) % SLOT;
        end
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
        chk("ldsel", 32'(ldsel), 32'(e_ldsel));
        chk("sseg", 32'(sseg_n), 32'(e_sseg));
        chk("frame_start", 32'(fs), 32'(e_fs));
        chk("onehot", 32'($countones(ldsel) <= 1), 32'd1);
    endtask

    task automatic run(input int cycles, input logic [N-1:0] e);
        en = e;
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    initial begin
        int fs_count;
        rst  = 1'b1;
        en   = 4'hF;
        in_n = {8'hB0, 8'hA4, 8'hF9, 8'hC0};
`ifdef SSEG_MUX_DIM_EN
        bright = 4'd8;
`endif
        m_pos = 0; m_idx = 0;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b0;

        // Directed scenarios: all enabled, alternate, none, single digit.
        run(3 * 4 * SLOT, 4'hF);
        run(4 * SLOT, 4'b0101);
        fs_count = 0;
        en = 4'b0000;
        for (int i = 0; i < 3 * SLOT; i++) begin
            cycle();
            if (fs) fs_count++;
        end
        chk("no_fs_when_off", 32'(fs_count), 32'd0);
        run(4 * SLOT, 4'b1000);

        // Mid-slot disable of the displayed digit, then mid-slot reset.
        run(SLOT + 5, 4'hF);
        en[m_idx] = 1'b0;
        run(2 * SLOT, en);
        run(2 * SLOT + SLOT / 2, 4'hF);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        run(2 * SLOT, 4'hF);
`ifdef SSEG_MUX_DIM_EN
        bright = 4'd0;
        run(2 * SLOT, 4'hF);
        bright = 4'd15;
        run(2 * SLOT, 4'hF);
`endif

        // Randomised traffic: enables, segment data, resets, brightness.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) en = N'($urandom);
            if ($urandom_range(0, 7) == 0)
                in_n[$urandom_range(0, N - 1)] = SEG_HEX_N[$urandom_range(0, 15)];
`ifdef SSEG_MUX_DIM_EN
            if ($urandom_range(0, 99) == 0) bright = 4'($urandom);
`endif
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
